// File: rtl/tfacc_arb_pkg.sv
// Shared types and constants for the input-channel read arbiter: channel ids,
// outstanding-tag depth and the round-robin pick helper.
package tfacc_arb_pkg;

  localparam int unsigned NP      = 48;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned MAX_OUT = 4;

  localparam int unsigned TAG_DEPTH = MAX_OUT;
  localparam int unsigned CH_W      = $clog2(NP);
  localparam int unsigned CNT_W     = $clog2(TAG_DEPTH) + 1;

  typedef logic [ADDR_W-1:0] u32_t;
  typedef logic [DATA_W-1:0] u8_t;
  typedef logic [CH_W-1:0]   ch_id_t;

  typedef struct packed {
    logic   found;
    ch_id_t id;
  } pick_t;

  typedef enum logic [0:0] {
    StIdle,
    StReq
  } arb_state_e;

  function automatic ch_id_t next_ch(input ch_id_t c);
    return (c == ch_id_t'(NP - 1)) ? '0 : c + 1'b1;
  endfunction

  // First eligible channel at or after ptr, modulo NP. Walking backwards lets
  // the smallest offset from ptr overwrite any farther candidate.
  function automatic pick_t rr_pick(input logic [NP-1:0] elig, input ch_id_t ptr);
    pick_t res;
    int    idx;
    res = '0;
    for (int k = int'(NP) - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= int'(NP)) idx = idx - int'(NP);
      if (elig[idx[CH_W-1:0]]) begin
        res.found = 1'b1;
        res.id    = idx[CH_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/tfacc_in_arb_if.sv
// Bundle of per-channel request/return signals and the shared read port.
interface tfacc_in_arb_if;
  import tfacc_arb_pkg::*;

  logic [NP-1:0] i_re;
  u32_t [NP-1:0] i_adr;
  logic [NP-1:0] i_rdy;
  u8_t  [NP-1:0] in_d;
  logic          m_re;
  u32_t          m_adr;
  logic          m_ack;
  logic          m_dv;
  u8_t           m_dr;
  logic          busy;
  logic          err;

  // Requester/memory side.
  modport master (
    output i_re, i_adr, m_ack, m_dv, m_dr,
    input  i_rdy, in_d, m_re, m_adr, busy, err
  );

  // Arbiter side.
  modport slave (
    input  i_re, i_adr, m_ack, m_dv, m_dr,
    output i_rdy, in_d, m_re, m_adr, busy, err
  );

endinterface

// File: rtl/tfacc_tag_fifo.sv
// Small FIFO of channel ids for reads accepted by the shared port but not yet
// returned. Push and pop in the same cycle are legal; caller never overflows.
module tfacc_tag_fifo
  import tfacc_arb_pkg::*;
#(
  parameter int unsigned Depth = TAG_DEPTH
) (
  input  logic                   clk,
  input  logic                   xrst,
  input  logic                   push,
  input  ch_id_t                 push_id,
  input  logic                   pop,
  output ch_id_t                 head,
  output logic [$clog2(Depth):0] count
);

  localparam int unsigned PW = $clog2(Depth);

  ch_id_t        mem_q [Depth];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [PW:0]   cnt_q;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= push_id;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/tfacc_in_arb.sv
// Round-robin arbiter serialising per-channel byte reads onto one shared read
// port and steering in-order returns back to the requesting channel.
module tfacc_in_arb
  import tfacc_arb_pkg::*;
(
  input logic           clk,
  input logic           xrst,
  tfacc_in_arb_if.slave bus
);

  localparam logic [CNT_W-1:0] MaxOut = CNT_W'(MAX_OUT);

  arb_state_e      state_q, state_d;
  u32_t            m_adr_q, m_adr_d;
  ch_id_t          gnt_q, gnt_d;
  ch_id_t          rr_q, rr_d;
  logic [NP-1:0]   pending_q, pending_d;
  logic [NP-1:0]   rdy_q, rdy_d;
  u8_t  [NP-1:0]   in_d_q;
  logic            err_q;

  logic            push;
  logic            pop;
  ch_id_t          head;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] occ;
  logic [NP-1:0]   gnt_mask;
  logic [NP-1:0]   ret_mask;
  logic [NP-1:0]   elig;
  ch_id_t          ptr;
  pick_t           pk;
  logic            can_pick;

  assign push = (state_q == StReq) && bus.m_ack;
  assign pop  = bus.m_dv && (cnt != '0);
  assign occ  = cnt + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    gnt_mask = '0;
    ret_mask = '0;
    if (push) gnt_mask[gnt_q] = 1'b1;
    if (pop)  ret_mask[head]  = 1'b1;
  end

  // The channel being acked and any channel mid-pulse are not yet visible in
  // pending_q, so they are masked here to avoid a duplicate grant.
  assign elig     = bus.i_re & ~pending_q & ~rdy_q & ~gnt_mask;
  assign ptr      = push ? next_ch(gnt_q) : rr_q;
  assign pk       = rr_pick(elig, ptr);
  assign can_pick = pk.found && (occ < MaxOut);

  always_comb begin
    state_d = state_q;
    m_adr_d = m_adr_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    case (state_q)
      StIdle: begin
        if (can_pick) begin
          state_d = StReq;
          m_adr_d = bus.i_adr[pk.id];
          gnt_d   = pk.id;
        end
      end
      StReq: begin
        if (push) begin
          rr_d = next_ch(gnt_q);
          if (can_pick) begin
            m_adr_d = bus.i_adr[pk.id];
            gnt_d   = pk.id;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign pending_d = (pending_q | gnt_mask) & ~ret_mask;
  assign rdy_d     = ret_mask;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q   <= StIdle;
      m_adr_q   <= '0;
      gnt_q     <= '0;
      rr_q      <= '0;
      pending_q <= '0;
      rdy_q     <= '0;
      in_d_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_adr_q   <= m_adr_d;
      gnt_q     <= gnt_d;
      rr_q      <= rr_d;
      pending_q <= pending_d;
      rdy_q     <= rdy_d;
      if (pop) in_d_q[head] <= bus.m_dr;
      if (bus.m_dv && (cnt == '0)) err_q <= 1'b1;
    end
  end

  tfacc_tag_fifo #(
    .Depth (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .xrst    (xrst),
    .push    (push),
    .push_id (gnt_q),
    .pop     (pop),
    .head    (head),
    .count   (cnt)
  );

  assign bus.m_re  = (state_q == StReq);
  assign bus.m_adr = m_adr_q;
  assign bus.i_rdy = rdy_q;
  assign bus.in_d  = in_d_q;
  assign bus.err   = err_q;
  assign bus.busy  = (state_q == StReq) | (cnt != '0) | (|pending_q);

endmodule

// File: tb/tb_tfacc_in_arb.sv
// Directed bench for tfacc_in_arb: a per-cycle vector table for a single read,
// then hand-written sequences for burst order, backpressure, full, wrap, reset.
module tb_tfacc_in_arb;
  import tfacc_arb_pkg::*;

  logic clk = 1'b0;
  logic xrst;
  always #5 clk = ~clk;

  tfacc_in_arb_if bus ();

  tfacc_in_arb dut (
    .clk  (clk),
    .xrst (xrst),
    .bus  (bus)
  );

  int n_chk   = 0;
  int n_fail  = 0;
  int n_proto = 0;

  logic [NP-1:0] inflight;

  typedef struct {
    logic [NP-1:0] re;
    logic          ack;
    logic          dv;
    logic [7:0]    dr;
    logic          e_mre;
    logic [31:0]   e_madr;
    logic [NP-1:0] e_rdy;
    logic          e_busy;
    logic          e_err;
    logic [7:0]    e_ind5;
  } vec_t;

  vec_t vt[6];

  function automatic u32_t adr_of(input int ch);
    return 32'h0B0 + 32'(ch) * 32'h10;
  endfunction

  function automatic logic [NP-1:0] bit_of(input int ch);
    logic [NP-1:0] m;
    m     = '0;
    m[ch] = 1'b1;
    return m;
  endfunction

  function automatic vec_t mk(input logic [NP-1:0] re, input logic ack, input logic dv,
                              input logic [7:0] dr, input logic e_mre, input logic [31:0] e_madr,
                              input logic [NP-1:0] e_rdy, input logic e_busy, input logic e_err,
                              input logic [7:0] e_ind5);
    vec_t v;
    v.re = re; v.ack = ack; v.dv = dv; v.dr = dr;
    v.e_mre = e_mre; v.e_madr = e_madr; v.e_rdy = e_rdy;
    v.e_busy = e_busy; v.e_err = e_err; v.e_ind5 = e_ind5;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    xrst       = 1'b0;
    bus.i_re   = '0;
    bus.m_ack  = 1'b0;
    bus.m_dv   = 1'b0;
    bus.m_dr   = '0;
    repeat (2) @(negedge clk);
    xrst = 1'b1;
  endtask

  // One read return; the matching channel must pulse next cycle with the data.
  task automatic ret_one(input int ch, input logic [7:0] d, input string tag);
    bus.m_dv = 1'b1;
    bus.m_dr = d;
    @(negedge clk);
    bus.m_dv = 1'b0;
    check({tag, "_rdy"}, 64'(bus.i_rdy), 64'(bit_of(ch)));
    check({tag, "_ind"}, 64'(bus.in_d[ch]), 64'(d));
    bus.i_re[ch] = 1'b0;
  endtask

  // A channel may only drop i_re once its i_rdy has been seen.
  always @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      inflight <= '0;
    end else begin
      if (|(inflight & ~bus.i_re & ~bus.i_rdy)) begin
        n_proto <= n_proto + 1;
        $display("FAIL proto: i_re dropped in flight 0x%0h", inflight & ~bus.i_re);
      end
      inflight <= (inflight | bus.i_re) & ~bus.i_rdy;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    int nexp;
    int nret;
    int exp_id;
    logic [NP-1:0] exp_rdy;
    logic [NP-1:0] m;
    int due[$];
    int qid[$];

    for (int ch = 0; ch < int'(NP); ch++) bus.i_adr[ch] = adr_of(ch);

    // ---- single request on channel 5, table driven ----
    vt[0] = mk(bit_of(5), 1'b0, 1'b0, 8'h00, 1'b0, 32'h0,   '0,        1'b0, 1'b0, 8'h00);
    vt[1] = mk(bit_of(5), 1'b1, 1'b0, 8'h00, 1'b1, 32'h100, '0,        1'b1, 1'b0, 8'h00);
    vt[2] = mk(bit_of(5), 1'b0, 1'b0, 8'h00, 1'b0, 32'h100, '0,        1'b1, 1'b0, 8'h00);
    vt[3] = mk(bit_of(5), 1'b0, 1'b1, 8'hA5, 1'b0, 32'h100, '0,        1'b1, 1'b0, 8'h00);
    vt[4] = mk('0,        1'b0, 1'b0, 8'h00, 1'b0, 32'h100, bit_of(5), 1'b0, 1'b0, 8'hA5);
    vt[5] = mk('0,        1'b0, 1'b0, 8'h00, 1'b0, 32'h100, '0,        1'b0, 1'b0, 8'hA5);

    do_reset();
    for (int r = 0; r < 6; r++) begin
      check($sformatf("t1_mre[%0d]", r),  64'(bus.m_re),    64'(vt[r].e_mre));
      check($sformatf("t1_madr[%0d]", r), 64'(bus.m_adr),   64'(vt[r].e_madr));
      check($sformatf("t1_rdy[%0d]", r),  64'(bus.i_rdy),   64'(vt[r].e_rdy));
      check($sformatf("t1_busy[%0d]", r), 64'(bus.busy),    64'(vt[r].e_busy));
      check($sformatf("t1_err[%0d]", r),  64'(bus.err),     64'(vt[r].e_err));
      check($sformatf("t1_ind[%0d]", r),  64'(bus.in_d[5]), 64'(vt[r].e_ind5));
      bus.i_re  = vt[r].re;
      bus.m_ack = vt[r].ack;
      bus.m_dv  = vt[r].dv;
      bus.m_dr  = vt[r].dr;
      @(negedge clk);
    end

    // ---- all channels, ack always, data 3 cycles after accept ----
    do_reset();
    bus.m_ack = 1'b1;
    bus.i_re  = '1;
    nexp = 0; nret = 0; exp_id = -1; exp_rdy = '0;
    for (int cyc = 0; cyc < 400 && nret < int'(NP); cyc++) begin
      @(negedge clk);
      check("t2_rdy", 64'(bus.i_rdy), 64'(exp_rdy));
      if (exp_id >= 0) begin
        check("t2_ind", 64'(bus.in_d[exp_id]), 64'(exp_id));
        bus.i_re[exp_id] = 1'b0;
        nret++;
      end
      if (bus.m_re) begin
        check("t2_order", 64'(bus.m_adr), 64'(adr_of(nexp)));
        due.push_back(cyc + 3);
        qid.push_back(nexp);
        nexp++;
      end
      exp_rdy  = '0;
      exp_id   = -1;
      bus.m_dv = 1'b0;
      if (due.size() > 0 && due[0] == cyc) begin
        bus.m_dv = 1'b1;
        bus.m_dr = 8'(qid[0]);
        exp_id   = qid[0];
        exp_rdy  = bit_of(qid[0]);
        void'(due.pop_front());
        void'(qid.pop_front());
      end
    end
    check("t2_nret", 64'(nret), 64'(NP));
    check("t2_err", 64'(bus.err), 64'd0);
    check("t2_busy", 64'(bus.busy), 64'd0);
    bus.m_ack = 1'b0;

    // ---- backpressure on channel 7, then pointer sits at 8 ----
    do_reset();
    bus.i_re = bit_of(7);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("t3_mre_hold", 64'(bus.m_re), 64'd1);
      check("t3_madr_hold", 64'(bus.m_adr), 64'(adr_of(7)));
    end
    bus.m_ack = 1'b1;
    @(negedge clk);
    check("t3_single", 64'(bus.m_re), 64'd0);
    bus.i_re = bit_of(7) | bit_of(3) | bit_of(9);
    @(negedge clk);
    check("t3_rr_first", 64'(bus.m_adr), 64'(adr_of(9)));
    @(negedge clk);
    check("t3_rr_second", 64'(bus.m_adr), 64'(adr_of(3)));
    @(negedge clk);
    check("t3_idle", 64'(bus.m_re), 64'd0);
    ret_one(7, 8'h77, "t3_r7");
    ret_one(9, 8'h99, "t3_r9");
    ret_one(3, 8'h33, "t3_r3");
    check("t3_busy", 64'(bus.busy), 64'd0);
    bus.m_ack = 1'b0;

    // ---- full tag FIFO: four accepts, refill on the pop cycle ----
    do_reset();
    m = '0;
    for (int ch = 10; ch < 16; ch++) m[ch] = 1'b1;
    bus.i_re  = m;
    bus.m_ack = 1'b1;
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.m_re) acc++;
    end
    check("t4_accepts", 64'(acc), 64'd4);
    check("t4_stalled", 64'(bus.m_re), 64'd0);
    bus.m_dv = 1'b1;
    bus.m_dr = 8'h3C;
    @(negedge clk);
    bus.m_dv = 1'b0;
    check("t4_refill_mre", 64'(bus.m_re), 64'd1);
    check("t4_refill_adr", 64'(bus.m_adr), 64'(adr_of(14)));
    check("t4_rdy10", 64'(bus.i_rdy), 64'(bit_of(10)));
    bus.i_re[10] = 1'b0;
    @(negedge clk);
    check("t4_full_again", 64'(bus.m_re), 64'd0);
    for (int ch = 11; ch < 16; ch++) ret_one(ch, 8'(8'h40 + ch), "t4_ret");
    check("t4_busy", 64'(bus.busy), 64'd0);

    // ---- pointer wrap 47 -> 0, then a spurious return ----
    do_reset();
    bus.m_ack = 1'b1;
    bus.i_re  = bit_of(46);
    @(negedge clk);
    check("t5_g46", 64'(bus.m_adr), 64'(adr_of(46)));
    @(negedge clk);
    ret_one(46, 8'h46, "t5_r46");
    bus.i_re = bit_of(47) | bit_of(0);
    @(negedge clk);
    check("t5_wrap_first", 64'(bus.m_adr), 64'(adr_of(47)));
    @(negedge clk);
    check("t5_wrap_second", 64'(bus.m_adr), 64'(adr_of(0)));
    @(negedge clk);
    check("t5_idle", 64'(bus.m_re), 64'd0);
    ret_one(47, 8'h47, "t5_r47");
    ret_one(0, 8'h5A, "t5_r0");
    @(negedge clk);
    check("t5_err_before", 64'(bus.err), 64'd0);
    bus.m_dv = 1'b1;
    bus.m_dr = 8'hFF;
    @(negedge clk);
    bus.m_dv = 1'b0;
    check("t5_err_set", 64'(bus.err), 64'd1);
    check("t5_no_rdy", 64'(bus.i_rdy), 64'd0);
    @(negedge clk);
    check("t5_err_sticky", 64'(bus.err), 64'd1);

    // ---- asynchronous reset with three reads outstanding ----
    bus.i_re = bit_of(20) | bit_of(21) | bit_of(22);
    repeat (4) @(negedge clk);
    check("t6_busy_pre", 64'(bus.busy), 64'd1);
    #2;
    xrst = 1'b0;
    #1;
    check("t6_mre", 64'(bus.m_re), 64'd0);
    check("t6_madr", 64'(bus.m_adr), 64'd0);
    check("t6_rdy", 64'(bus.i_rdy), 64'd0);
    check("t6_ind", 64'(|bus.in_d), 64'd0);
    check("t6_busy", 64'(bus.busy), 64'd0);
    check("t6_err", 64'(bus.err), 64'd0);
    bus.i_re  = '0;
    bus.m_ack = 1'b0;
    @(negedge clk);
    xrst = 1'b1;
    bus.m_dv = 1'b1;
    bus.m_dr = 8'h11;
    @(negedge clk);
    bus.m_dv = 1'b0;
    check("t6_late_err", 64'(bus.err), 64'd1);
    check("t6_late_rdy", 64'(bus.i_rdy), 64'd0);

    @(negedge clk);
    n_fail = n_fail + n_proto;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
